key_expand_seq: RTL and testbench
=================================

KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 SHALL have no parameters; key length is selected at run time.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  begin expansion; sampled only in IDLE.
REQ-005 SHALL have port: key_len  input  2  key length: 00=128, 01=192, 10=256, 11 treated as 128; sampled with start.
REQ-006 SHALL have port: key  input  256  cipher key, MSB-first, word w0 = key[255:224]; 128 uses [255:128], 192 uses [255:64]; sampled with start.
REQ-007 SHALL have port: busy  output  1  high in every state other than IDLE.
REQ-008 SHALL have port: rk_valid  output  1  rk/rk_idx hold a valid round key.
REQ-009 SHALL have port: rk_ready  input  1  consumer accepts rk; transfer when rk_valid && rk_ready.
REQ-010 SHALL have port: rk  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-011 SHALL have port: rk_idx  output  4  round number r of rk (0..Nr).
REQ-012 SHALL have port: done  output  1  one-cycle pulse on the cycle after the final round key transfers.

Function
REQ-013 SHALL use Nk/Nr = 4/10, 6/12, 8/14 and produce 4*(Nr+1) = 44/52/60 words w[i].
REQ-014 SHALL produce exactly one word per non-stalled RUN cycle, including the key words: w[i] = key word i for i<Nk.
REQ-015 SHALL compute, for i>=Nk, w[i] = w[i-Nk] xor temp, where temp is one of three cases.
REQ-016 SHALL use temp = SubWord(RotWord(w[i-1])) xor {rcon,24'h0} when i mod Nk = 0.
REQ-017 SHALL use temp = SubWord(w[i-1]) when Nk=8 and i mod 8 = 4.
REQ-018 SHALL use temp = w[i-1] in all other cases.
REQ-019 SHALL keep the last Nk words in an 8x32 history shift register; no full key table is stored.
REQ-020 SHALL load rcon = 8'h01 at start and update it to xtime(rcon) after each i mod Nk = 0 word: shift left 1, xor 8'h1B if the old bit 7 was set. Sequence: 01,02,04,08,10,20,40,80,1B,36.
REQ-021 SHALL collect words into a 4-word assembly register; the 4th word SHALL move it into rk on the same edge if rk_valid=0 or rk_valid&&rk_ready that cycle, otherwise word production stalls with all state held.
REQ-022 SHALL, with rk_ready held high, assert rk_valid for 1 cycle every 4 cycles; start at edge k gives rk0 valid after edge k+4.
REQ-023 SHALL keep rk, rk_idx and rk_valid stable while rk_valid && !rk_ready.
REQ-024 SHALL implement FSM IDLE -> RUN on start; RUN -> LAST after the final word is produced; LAST -> IDLE when the final rk transfers, with done pulsed.
REQ-025 SHALL ignore start while busy, including start asserted in the same cycle as done.
REQ-026 SHALL use modulo-Nk word-position counters that wrap without arithmetic overflow; the word index i SHALL be 6 bits.

Reset
REQ-027 SHALL, on rst high at a clock edge, return to IDLE from any state, including mid-RUN or mid-stall, and discard the partial key.
REQ-028 SHALL drive busy=0, rk_valid=0, done=0, rk=0, rk_idx=0 after reset; history, assembly and rcon registers SHALL be cleared.
REQ-029 SHALL let rst override start asserted in the same cycle.

Structure
REQ-030 SHALL place the key_len encodings, Nk/Nr per length, RCON_INIT=8'h01, the 8'h1B reduction constant and the FSM state enum in shared package aes_pkg.
REQ-031 SHALL instantiate exactly one sub-module, sub_word (four existing sbox instances, 32-bit in/out), shared between the rcon step and the Nk=8 step; there SHALL be no other S-box usage.

Verification
REQ-032 SHALL cover 128-bit key 2b7e1516 28aed2a6 abf71588 09cf4f3c with rk_ready=1 -> rk0 = key, rk_idx 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, done pulses once, 44 cycles from start to last word.
REQ-033 SHALL cover 192-bit key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> rk_idx 12 = e98ba06f 448c773c 8ecc7204 01002202.
REQ-034 SHALL cover 256-bit key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> rk_idx 14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-035 SHALL cover random rk_ready backpressure on the 128 vector -> identical 11 round keys in order, rk stable while stalled, no key dropped or duplicated.
REQ-036 SHALL cover rst asserted mid-RUN, then start with a 256 key -> busy/rk_valid 0 the cycle after reset, fresh rk0 equal to the new key, correct rk_idx 14.
REQ-037 SHALL cover start pulsed while busy -> ignored; output sequence unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared key-length encodings, round counts, constants and FSM states
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] GF_REDUCE = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST
    } state_e;

    // Encoding 2'b11 falls back to the 128-bit key.
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_192: return NK_192;
            KEY_LEN_256: return NK_256;
            default:     return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_192: return NR_192;
            KEY_LEN_256: return NR_256;
            default:     return NR_128;
        endcase
    endfunction

    // Index of the final word, 4*(Nr+1)-1 = 4*Nr+3.
    function automatic logic [5:0] last_word_of(input logic [1:0] key_len);
        return {nr_of(key_len), 2'b11};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - byte substitution: GF(2^8) inverse followed by the affine map
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    // Inverse as a^254 through an addition chain; 0 maps to 0 naturally.
    assign x2   = gmul(a, a);
    assign x3   = gmul(x2, a);
    assign x6   = gmul(x3, x3);
    assign x12  = gmul(x6, x6);
    assign x15  = gmul(x12, x3);
    assign x30  = gmul(x15, x15);
    assign x60  = gmul(x30, x30);
    assign x120 = gmul(x60, x60);
    assign x240 = gmul(x120, x120);
    assign inv  = gmul(gmul(x240, x12), x2);

    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/sub_word.sv
// rtl/sub_word.sv - SubWord over one 32-bit word using four byte S-boxes
module sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    sbox u_sbox3 (.a(din[31:24]), .s(dout[31:24]));
    sbox u_sbox2 (.a(din[23:16]), .s(dout[23:16]));
    sbox u_sbox1 (.a(din[15:8]),  .s(dout[15:8]));
    sbox u_sbox0 (.a(din[7:0]),   .s(dout[7:0]));

endmodule

// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - sequential key expansion, one word per cycle, round keys on a valid/ready port
module key_expand_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         done
);

    // Key words land at the top of the history window so that hist[8-Nk]
    // always holds w[i-Nk] and hist[7] holds w[i-1] once shifting starts.
    function automatic logic [7:0][31:0] preload(input logic [255:0] k, input logic [3:0] nk);
        logic [7:0][31:0] h;
        h = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(nk)) h[3'(8 - int'(nk) + j)] = k[32*(7-j) +: 32];
        end
        return h;
    endfunction

    state_e           state_q, state_d;
    logic [7:0][31:0] hist_q;
    logic [2:0][31:0] asm_q;
    logic [3:0]       nk_q;
    logic [5:0]       last_q;
    logic [5:0]       i_q;
    logic [2:0]       pos_q;
    logic [1:0]       wpos_q;
    logic [3:0]       rnd_q;
    logic [7:0]       rcon_q;
    logic [127:0]     rk_q;
    logic [3:0]       rk_idx_q;
    logic             rk_valid_q;
    logic             done_q;

    logic        accept, advance, rk_xfer, load_rk, is_key;
    logic [31:0] w_old, w_prev, sw_in, sw_out, temp, word;

    assign accept  = (state_q == ST_IDLE) && start && !done_q;
    assign rk_xfer = rk_valid_q && rk_ready;
    assign advance = (state_q == ST_RUN) && ((wpos_q != 2'd3) || !rk_valid_q || rk_ready);
    assign load_rk = advance && (wpos_q == 2'd3);
    assign is_key  = i_q < {2'b00, nk_q};
    assign w_old   = hist_q[3'(4'd8 - nk_q)];
    assign w_prev  = hist_q[7];
    assign sw_in   = (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    sub_word u_sub_word (.din(sw_in), .dout(sw_out));

    // Pick the temp term for the current word position and form the new word.
    always_comb begin
        temp = w_prev;
        if (pos_q == 3'd0) begin
            temp = sw_out ^ {rcon_q, 24'h0};
        end else if ((nk_q == NK_256) && (pos_q == 3'd4)) begin
            temp = sw_out;
        end
        word = is_key ? w_old : (w_old ^ temp);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (advance && (i_q == last_q)) state_d = ST_LAST;
            ST_LAST: if (rk_xfer) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Word datapath: history shift, counters, rcon, assembly and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q     <= '0;
            asm_q      <= '0;
            nk_q       <= '0;
            last_q     <= '0;
            i_q        <= '0;
            pos_q      <= '0;
            wpos_q     <= '0;
            rnd_q      <= '0;
            rcon_q     <= '0;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == ST_LAST) && rk_xfer;
            if (accept) begin
                hist_q <= preload(key, nk_of(key_len));
                nk_q   <= nk_of(key_len);
                last_q <= last_word_of(key_len);
                i_q    <= '0;
                pos_q  <= '0;
                wpos_q <= '0;
                rnd_q  <= '0;
                rcon_q <= RCON_INIT;
            end else if (advance) begin
                hist_q <= {word, hist_q[7:1]};
                i_q    <= i_q + 6'd1;
                pos_q  <= ({1'b0, pos_q} == (nk_q - 4'd1)) ? 3'd0 : pos_q + 3'd1;
                wpos_q <= wpos_q + 2'd1;
                if (!is_key && (pos_q == 3'd0)) rcon_q <= xtime(rcon_q);
                case (wpos_q)
                    2'd0: asm_q[0] <= word;
                    2'd1: asm_q[1] <= word;
                    2'd2: asm_q[2] <= word;
                    default: begin
                        rk_q     <= {asm_q[0], asm_q[1], asm_q[2], word};
                        rk_idx_q <= rnd_q;
                        rnd_q    <= rnd_q + 4'd1;
                    end
                endcase
            end
            if (load_rk)      rk_valid_q <= 1'b1;
            else if (rk_xfer) rk_valid_q <= 1'b0;
        end
    end

    assign rk       = rk_q;
    assign rk_idx   = rk_idx_q;
    assign rk_valid = rk_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// tb/tb_key_expand_seq.sv - directed vectors against a behavioural key-expansion model
module tb_key_expand_seq;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key = '0;
    logic         rk_ready = 1'b1;
    logic         busy, rk_valid, done;
    logic [127:0] rk;
    logic [3:0]   rk_idx;

    key_expand_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
        .rk_idx(rk_idx), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: S-box built from the 3 / 1/3 generator walk, then the textbook expansion.
    logic [7:0]   sb [256];
    logic [31:0]  ew [60];
    logic [127:0] exp_rk [15];
    int           exp_nr;

    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic void model_expand(input logic [1:0] kl, input logic [255:0] k);
        int nk;
        logic [31:0] t;
        logic [7:0] rc;
        nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
        exp_nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ew[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(exp_nr+1); i++) begin
            t = ew[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            ew[i] = ew[i-nk] ^ t;
        end
        for (int r = 0; r <= exp_nr; r++) exp_rk[r] = {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
    endfunction

    logic [131:0] sbq [$];
    logic [127:0] cap_rk [16];
    bit  checking = 0;
    bit  rand_mode = 0;
    bit  prev_stall = 0;
    int  done_cnt, first_valid, last_valid, start_cyc;

    always @(posedge clk) begin
        #1;
        rk_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Compare DUT outputs against the expected round-key queue every cycle.
    always @(negedge clk) begin
        if (rst || !checking) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("stall_valid_hold", rk_valid, 1);
            if (rk_valid) begin
                chk("busy_with_rk", busy, 1);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rk: got idx %0d expected no round key", rk_idx);
                end else begin
                    chk("rk", rk, sbq[0][127:0]);
                    chk("rk_idx", rk_idx, sbq[0][131:128]);
                    if (rk_idx == 0 && first_valid < 0) first_valid = cyc;
                    if (rk_idx == exp_nr && last_valid < 0) last_valid = cyc;
                    if (rk_ready) begin
                        cap_rk[rk_idx] = rk;
                        void'(sbq.pop_front());
                    end
                end
            end
            prev_stall = rk_valid && !rk_ready;
            if (done) begin
                done_cnt++;
                chk("done_after_last_rk", sbq.size(), 0);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_key(input logic [1:0] kl, input logic [255:0] k, input bit rand_rdy, input bit pulse_busy);
        model_expand(kl, k);
        for (int r = 0; r <= exp_nr; r++) sbq.push_back({4'(r), exp_rk[r]});
        done_cnt = 0;
        first_valid = -1;
        last_valid = -1;
        @(posedge clk); #1;
        rand_mode = rand_rdy;
        checking = 1;
        key_len = kl;
        key = k;
        start = 1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 0;
        for (int n = 0; n < 1000 && done_cnt == 0; n++) begin
            @(negedge clk); #1;
            if (pulse_busy && n == 12) begin
                start = 1;
                key = ~k;
                key_len = 2'b10;
            end else if (pulse_busy && n == 13) begin
                start = 0;
            end
        end
        chk("done_seen", done_cnt, 1);
        if (pulse_busy) begin
            start = 1;
            @(posedge clk); #1;
            start = 0;
            chk("start_with_done_ignored", busy, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("all_rk_delivered", sbq.size(), 0);
        chk("idle_after_run", busy, 0);
        if (!rand_rdy) begin
            chk("rk0_latency", first_valid - start_cyc, 4);
            chk("last_word_latency", last_valid - start_cyc, 4*(exp_nr+1));
        end
        checking = 0;
        rand_mode = 0;
        sbq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        build_sbox();
        chk("model_sbox_00", sb[0], 8'h63);
        chk("model_sbox_53", sb[8'h53], 8'hed);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rk_valid", rk_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_rk", rk, 0);
        chk("reset_rk_idx", rk_idx, 0);
        @(posedge clk); #1;
        rst = 0;

        run_key(2'b00, K128, 0, 0);
        chk("aes128_rk0", cap_rk[0], K128[255:128]);
        chk("aes128_rk10", cap_rk[10], R128_10);

        run_key(2'b01, K192, 0, 0);
        chk("aes192_rk12", cap_rk[12], R192_12);

        run_key(2'b10, K256, 0, 0);
        chk("aes256_rk14", cap_rk[14], R256_14);

        run_key(2'b00, {K128[255:128], 128'hdeadbeef_0badf00d_12345678_9abcdef0}, 1, 0);
        chk("backpressure_rk10", cap_rk[10], R128_10);

        run_key(2'b11, K128, 0, 1);
        chk("len11_rk10", cap_rk[10], R128_10);

        @(posedge clk); #1;
        key_len = 2'b00;
        key = K128;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_rk_valid", rk_valid, 0);
        chk("midrun_reset_rk", rk, 0);
        chk("midrun_reset_rk_idx", rk_idx, 0);

        @(posedge clk); #1;
        rst = 1;
        start = 1;
        @(posedge clk); #1;
        rst = 0;
        start = 0;
        @(negedge clk);
        chk("reset_over_start_busy", busy, 0);

        run_key(2'b10, K256, 0, 0);
        chk("post_reset_rk0", cap_rk[0], K256[255:128]);
        chk("post_reset_rk14", cap_rk[14], R256_14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
